// File: rtl/locked_seg_adder_pkg.sv
// Shared types and constants for the key-locked segmented adder pipeline.
// No logic; state encoding and default unlock key only.
// Imported by the pipeline top.
package locked_seg_adder_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic [7:0] LOCK_KEY_DEFAULT = 8'hB4;

endpackage

// File: rtl/seg_add_stage.sv
// One registered SEG_W-bit adder segment with key-controlled carry-in and sum inversion.
// Latency: 1 cycle from inputs to sum_o/cout_o/vld_o.
// Backpressure: all outputs hold while en_i is low.
module seg_add_stage #(
    parameter int SEG_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             cin_i,
    input  logic             inv_cin_i,
    input  logic             inv_sum_i,
    output logic             vld_o,
    output logic [SEG_W-1:0] sum_o,
    output logic             cout_o
);

    logic [SEG_W:0] raw;

    // Carry-out is taken before the sum inversion so a wrong key cannot hide it.
    assign raw = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, cin_i ^ inv_cin_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_o  <= 1'b0;
            sum_o  <= '0;
            cout_o <= 1'b0;
        end else if (en_i) begin
            vld_o  <= vld_i;
            sum_o  <= raw[SEG_W-1:0] ^ {SEG_W{inv_sum_i}};
            cout_o <= raw[SEG_W];
        end
    end

endmodule

// File: rtl/locked_seg_adder_pipe.sv
// NSEG-stage segmented adder; each result is scrambled unless key_q matches LOCK_KEY.
// Latency: NSEG cycles from acceptance to out_valid_o, one result per cycle.
// Backpressure: global stall when out_valid_o && !out_ready_i; key changes wait for an empty pipe.
module locked_seg_adder_pipe
    import locked_seg_adder_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter int                NSEG     = 4,
    parameter logic [2*NSEG-1:0] LOCK_KEY = LOCK_KEY_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [WIDTH-1:0]    add1_i,
    input  logic [WIDTH-1:0]    add2_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [2*NSEG-1:0]   key_i,
    input  logic                key_load_i,
    output logic [WIDTH:0]      result_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                key_ok_o
);

    localparam int SEG_W = WIDTH / NSEG;

    state_t               state_q;
    logic [2*NSEG-1:0]    key_q;
    logic [2*NSEG-1:0]    pend_q;
    logic [2*NSEG-1:0]    e;
    logic                 key_ok_q;
    logic                 advance;
    logic                 accept;
    logic                 pipe_empty;
    logic [NSEG-1:0]      vld;
    logic [NSEG-1:0]      cout;
    logic [SEG_W-1:0]     seg_sum [NSEG];
    logic [WIDTH-1:0]     a_q     [NSEG-1];
    logic [WIDTH-1:0]     b_q     [NSEG-1];
    logic [WIDTH-1:0]     acc_q   [NSEG-1];
    logic [WIDTH-1:0]     acc_nxt [NSEG-1];

    assign out_valid_o = vld[NSEG-1];
    assign advance     = ~out_valid_o | out_ready_i;
    assign in_ready_o  = advance & (state_q == RUN) & ~key_load_i & ~rst_i;
    assign accept      = in_valid_i & in_ready_o;
    assign pipe_empty  = ~|vld;
    // key_q only changes with an empty pipe, so every result in flight sees its acceptance key.
    assign e           = key_q ^ LOCK_KEY;
    assign key_ok_o    = key_ok_q;
    assign result_o    = {cout[NSEG-1], seg_sum[NSEG-1], acc_q[NSEG-2][WIDTH-SEG_W-1:0]};

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        logic [SEG_W-1:0] a_seg;
        logic [SEG_W-1:0] b_seg;
        logic             cin;
        logic             vin;

        if (s == 0) begin : g_src
            assign a_seg = add1_i[SEG_W-1:0];
            assign b_seg = add2_i[SEG_W-1:0];
            assign cin   = 1'b0;
            assign vin   = accept;
        end else begin : g_src
            assign a_seg = a_q[s-1][s*SEG_W +: SEG_W];
            assign b_seg = b_q[s-1][s*SEG_W +: SEG_W];
            assign cin   = cout[s-1];
            assign vin   = vld[s-1];
        end

        seg_add_stage #(.SEG_W(SEG_W)) u_stage (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .en_i      (advance),
            .vld_i     (vin),
            .a_i       (a_seg),
            .b_i       (b_seg),
            .cin_i     (cin),
            .inv_cin_i (e[2*s]),
            .inv_sum_i (e[2*s+1]),
            .vld_o     (vld[s]),
            .sum_o     (seg_sum[s]),
            .cout_o    (cout[s])
        );
    end

    // acc_q[k] travels with stage k+1 and holds the finished segments 0..k.
    always_comb begin
        acc_nxt[0]              = '0;
        acc_nxt[0][SEG_W-1:0]   = seg_sum[0];
        for (int k = 1; k < NSEG-1; k++) begin
            acc_nxt[k]                    = acc_q[k-1];
            acc_nxt[k][k*SEG_W +: SEG_W]  = seg_sum[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NSEG-1; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                acc_q[k] <= '0;
            end
        end else if (advance) begin
            a_q[0] <= add1_i;
            b_q[0] <= add2_i;
            for (int k = 1; k < NSEG-1; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 0; k < NSEG-1; k++) begin
                acc_q[k] <= acc_nxt[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= RUN;
            key_q    <= '0;
            pend_q   <= '0;
            key_ok_q <= 1'b0;
        end else begin
            key_ok_q <= (key_q == LOCK_KEY);
            case (state_q)
                RUN: begin
                    if (key_load_i) begin
                        if (pipe_empty) begin
                            key_q <= key_i;
                        end else begin
                            pend_q  <= key_i;
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (key_load_i) begin
                        pend_q <= key_i;
                    end
                    // A request arriving on the draining edge is the newest, so it wins.
                    if (pipe_empty) begin
                        key_q   <= key_load_i ? key_i : pend_q;
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_locked_seg_adder_pipe.sv
// Directed bench for locked_seg_adder_pipe (WIDTH=32, NSEG=4, LOCK_KEY=8'hB4).
module tb_locked_seg_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] add1;
    logic [31:0] add2;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  key;
    logic        key_load;
    logic [32:0] result;
    logic        out_valid;
    logic        out_ready;
    logic        key_ok;

    int checks   = 0;
    int failures = 0;

    locked_seg_adder_pipe #(.WIDTH(32), .NSEG(4), .LOCK_KEY(8'hB4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .add1_i      (add1),
        .add2_i      (add2),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .key_i       (key),
        .key_load_i  (key_load),
        .result_o    (result),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .key_ok_o    (key_ok)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load a key with an empty pipe while also offering operands, then check key_ok_o.
    task automatic load_key(input logic [7:0] k, input logic exp_ok);
        @(negedge clk);
        key = k; key_load = 1'b1; in_valid = 1'b1; add1 = 32'h0; add2 = 32'h0;
        #1 chk("key_load_prio_rdy", in_ready, 1'b0);
        @(negedge clk);
        key_load = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("key_ok", key_ok, exp_ok);
    endtask

    // One isolated operand pair; checks exact 4-cycle latency and the sum.
    task automatic single(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp, input string tag);
        @(negedge clk);
        add1 = a; add2 = b; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, in_ready, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_early"}, out_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk(tag, result, exp);
    endtask

    task automatic wait_result(input logic [32:0] exp, input string tag);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk(tag, result, exp);
    endtask

    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic [32:0] sx [8];

    initial begin
        int sent, got, stale;
        logic hold_vld, drained;
        logic [32:0] held;

        sa[0] = 32'h00000001; sb[0] = 32'h00000002; sx[0] = 33'h0_00000003;
        sa[1] = 32'h00000010; sb[1] = 32'h00000020; sx[1] = 33'h0_00000030;
        sa[2] = 32'h12345678; sb[2] = 32'h11111111; sx[2] = 33'h0_23456789;
        sa[3] = 32'hFFFFFFFF; sb[3] = 32'hFFFFFFFF; sx[3] = 33'h1_FFFFFFFE;
        sa[4] = 32'h80000000; sb[4] = 32'h80000000; sx[4] = 33'h1_00000000;
        sa[5] = 32'h000000FF; sb[5] = 32'h00000001; sx[5] = 33'h0_00000100;
        sa[6] = 32'h0000FFFF; sb[6] = 32'h00000001; sx[6] = 33'h0_00010000;
        sa[7] = 32'h7FFFFFFF; sb[7] = 32'h00000001; sx[7] = 33'h0_80000000;

        rst = 1'b1; add1 = '0; add2 = '0; in_valid = 1'b0; key = '0;
        key_load = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 33'h0);
        chk("rst_key_ok", key_ok, 1'b0);
        @(negedge clk); rst = 1'b0;

        load_key(8'hB4, 1'b1);
        single(32'h29AF2430, 32'h7A1B9ABC, 33'h0_A3CABEEC, "b4_sum");
        single(32'hFFFFFFFF, 32'h00000001, 33'h1_00000000, "b4_carry_out");
        single(32'h00000000, 32'h00000000, 33'h0_00000000, "b4_zero");

        load_key(8'hB5, 1'b0);
        single(32'h29AF2430, 32'h7A1B9ABC, 33'h0_A3CABEED, "b5_cin_inv");
        load_key(8'hB6, 1'b0);
        single(32'h29AF2430, 32'h7A1B9ABC, 33'h0_A3CABE13, "b6_sum_inv");

        // Stream of 8 with a 3-cycle output stall mid-stream.
        load_key(8'hB4, 1'b1);
        sent = 0; got = 0; hold_vld = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 8);
            add1 = (sent < 8) ? sa[sent] : 32'h0;
            add2 = (sent < 8) ? sb[sent] : 32'h0;
            #1;
            if (!out_ready) begin
                chk("stall_vld", out_valid, 1'b1);
                if (hold_vld) chk("stall_hold", result, held);
                held = result; hold_vld = 1'b1;
            end else begin
                hold_vld = 1'b0;
            end
            if (out_valid && out_ready) begin
                chk("stream_sum", result, sx[got]);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", got, 8);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("stream_no_dup", stale, 0);

        // Key request with three results in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            add1 = 32'h29AF2430; add2 = 32'h7A1B9ABC; in_valid = 1'b1;
        end
        @(negedge clk);
        key = 8'hB5; key_load = 1'b1;
        #1 chk("drain_kl_rdy", in_ready, 1'b0);
        got = 0; drained = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            key_load = 1'b0;
            #1;
            if (out_valid) begin
                chk("drain_old_key", result, 33'h0_A3CABEEC);
                got++;
            end
            if (in_ready) begin
                drained = 1'b1;
                break;
            end
        end
        chk("drain_count", got, 3);
        chk("drain_reopen", drained, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        wait_result(33'h0_A3CABEED, "drain_new_key");
        chk("drain_key_ok", key_ok, 1'b0);

        // Reset with a full, stalled pipeline.
        load_key(8'hB4, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            add1 = sa[i]; add2 = sb[i]; in_valid = 1'b1;
        end
        @(negedge clk); in_valid = 1'b0;
        chk("full_vld", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_key_ok", key_ok, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("midrst_no_stale", stale, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
